// File: rtl/dot_accum_dp.sv
// -----------------------------------------------------------------------------
// dot_accum_dp
//
// Data-side consumer for the dual-port address generator. Every Load beat from
// the generator puts two A addresses and two B addresses on the RAMs. The read
// data comes back RAM_LAT cycles later. This block multiplies the two A/B
// pairs, accumulates N/2 beats into one dot product, and writes each finished
// C element to the result RAM at its row-major address (row*N + col).
//
// Optional feature macro: DOT_ACCUM_SAT_EN
//   defined   : dataC saturates to 2**OUT_W-1, and an extra 'sat' output
//               pulses together with wrC whenever clamping happened.
//   undefined : dataC is the low OUT_W bits of the sum, and there is no 'sat'.
//
// Ports
//   clk      in   1        rising-edge clock
//   reset    in   1        synchronous active-high reset
//   Load     in   1        generator beat (addresses presented this cycle)
//   dataA1   in   DATA_W   A RAM port 1 read data
//   dataA2   in   DATA_W   A RAM port 2 read data
//   dataB1   in   DATA_W   B RAM port 1 read data
//   dataB2   in   DATA_W   B RAM port 2 read data
//   wrC      out  1        one-cycle write strobe to the C RAM
//   addrC    out  ADDR_W   C write address, row*N + col
//   dataC    out  OUT_W    C element value
//   busy     out  1        a dot product is partially accumulated
//   done     out  1        all N*N elements written (sticky until reset)
//   sat      out  1        (DOT_ACCUM_SAT_EN only) clamp flag, valid with wrC
// -----------------------------------------------------------------------------
module dot_accum_dp #(
  parameter int N       = 8,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 16,
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Load,
  input  logic [DATA_W-1:0] dataA1,
  input  logic [DATA_W-1:0] dataA2,
  input  logic [DATA_W-1:0] dataB1,
  input  logic [DATA_W-1:0] dataB2,
  output logic              wrC,
  output logic [ADDR_W-1:0] addrC,
  output logic [OUT_W-1:0]  dataC,
  output logic              busy,
  output logic              done
`ifdef DOT_ACCUM_SAT_EN
  ,
  output logic              sat
`endif
);

  localparam int BEATS  = N / 2;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  // State
  logic [RAM_LAT-1:0] r_load_dly;
  logic [BEAT_W-1:0]  r_beat;
  logic [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]   r_row;
  logic [IDX_W-1:0]   r_col;
  logic               r_wrC;
  logic               r_final_wr;
  logic               r_done;
  logic [ADDR_W-1:0]  r_addrC;
  logic [OUT_W-1:0]   r_dataC;

  // Combinational
  logic               w_vld;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_last_elem;
  logic [ACC_W-1:0]   w_prod1;
  logic [ACC_W-1:0]   w_prod2;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W-1:0]   w_sum;
  logic [ADDR_W-1:0]  w_addr;
  logic [OUT_W-1:0]   w_out;

  // Read data for a Load beat arrives RAM_LAT cycles after the beat.
  assign w_vld = r_load_dly[RAM_LAT-1];

  // Beats are ignored once done is set. They are also ignored in the single
  // cycle between the last strobe and done rising. Otherwise a stray beat
  // there would leave a partial sum (and busy) behind forever.
  assign w_accept    = w_vld & ~r_done & ~r_final_wr;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_last_elem = (r_row == IDX_W'(N - 1)) && (r_col == IDX_W'(N - 1));

  // Full-width unsigned arithmetic. A new element starts from zero, so the
  // old sum never needs an explicit clear between elements.
  assign w_prod1 = ACC_W'(dataA1) * ACC_W'(dataB1);
  assign w_prod2 = ACC_W'(dataA2) * ACC_W'(dataB2);
  assign w_base  = (r_beat == '0) ? '0 : r_acc;
  assign w_sum   = w_base + w_prod1 + w_prod2;

  assign w_addr = ADDR_W'(r_row) * ADDR_W'(N) + ADDR_W'(r_col);

`ifdef DOT_ACCUM_SAT_EN
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  logic w_clamp;
  logic r_sat;
  assign w_clamp = (CMP_W'(w_sum) > CMP_W'({OUT_W{1'b1}}));
  assign w_out   = w_clamp ? {OUT_W{1'b1}} : OUT_W'(w_sum);
  assign sat     = r_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_accept & w_last_beat & w_clamp;
    end
  end
`else
  assign w_out = OUT_W'(w_sum);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_dly <= '0;
      r_beat     <= '0;
      r_acc      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_wrC      <= 1'b0;
      r_final_wr <= 1'b0;
      r_done     <= 1'b0;
      r_addrC    <= '0;
      r_dataC    <= '0;
    end else begin
      r_load_dly[0] <= Load;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_load_dly[i] <= r_load_dly[i-1];
      end

      r_wrC      <= 1'b0;
      r_final_wr <= 1'b0;
      if (r_final_wr) begin
        r_done <= 1'b1;
      end

      if (w_accept) begin
        r_acc <= w_sum;
        if (w_last_beat) begin
          r_beat     <= '0;
          r_wrC      <= 1'b1;
          r_addrC    <= w_addr;
          r_dataC    <= w_out;
          r_final_wr <= w_last_elem;
          if (r_col == IDX_W'(N - 1)) begin
            r_col <= '0;
            r_row <= (r_row == IDX_W'(N - 1)) ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

  assign wrC   = r_wrC;
  assign addrC = r_addrC;
  assign dataC = r_dataC;
  assign busy  = (r_beat != '0);
  assign done  = r_done;

endmodule
